mac_pipelined: RTL and testbench

//  Parametrised multiply-accumulate unit, successor to the single-lane MAC.

---
 rtl/mac_pipelined.sv | 143 ++++++++++++++
 tb/tb_mac_pipelined.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipelined.sv
// Multi-lane multiply-accumulate: stage 1 forms the lane dot product, stage 2 accumulates
// with saturate-or-wrap, and an output register presents a one-cycle result pulse.
module mac_pipelined #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LANES      = 1,
    parameter int SATURATE   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic                        signed_mode,
    input  logic                        clear,
    input  logic [LANES*DATA_WIDTH-1:0] B,
    input  logic [LANES*DATA_WIDTH-1:0] C,
    output logic                        out_valid,
    output logic [ACC_WIDTH-1:0]        result,
    output logic                        sat_flag
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
    // Two guard bits above the wider operand keep the exact sum free of overflow in both modes.
    localparam int EXT_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 2;

    localparam logic [EXT_W-1:0] SMAX_EXT = {{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [EXT_W-1:0] SMIN_EXT = {{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [EXT_W-1:0] UMAX_EXT = {{(EXT_W-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [SUM_W-1:0]     lane_sum;
    logic                 s1_valid;
    logic                 s1_last;
    logic                 s1_signed;
    logic [SUM_W-1:0]     s1_sum;

    logic                 s2_valid;
    logic                 s2_last;
    logic                 acc_open;
    logic                 sticky;
    logic [ACC_WIDTH-1:0] acc;

    logic [EXT_W-1:0]     acc_ext;
    logic [EXT_W-1:0]     sum_ext;
    logic [EXT_W-1:0]     exact;
    logic                 over_hi;
    logic                 over_lo;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 sticky_next;

    always_comb begin
        logic [DATA_WIDTH-1:0] b_k;
        logic [DATA_WIDTH-1:0] c_k;
        logic [PROD_W-1:0]     prod;
        lane_sum = '0;
        b_k      = '0;
        c_k      = '0;
        prod     = '0;
        for (int k = 0; k < LANES; k++) begin
            b_k = B[k*DATA_WIDTH +: DATA_WIDTH];
            c_k = C[k*DATA_WIDTH +: DATA_WIDTH];
            // Low PROD_W bits of the extended-operand product equal the exact product in either mode.
            if (signed_mode) begin
                prod = {{DATA_WIDTH{b_k[DATA_WIDTH-1]}}, b_k} * {{DATA_WIDTH{c_k[DATA_WIDTH-1]}}, c_k};
            end else begin
                prod = {{DATA_WIDTH{1'b0}}, b_k} * {{DATA_WIDTH{1'b0}}, c_k};
            end
            lane_sum = lane_sum + {{(SUM_W-PROD_W){signed_mode & prod[PROD_W-1]}}, prod};
        end
    end

    always_comb begin
        acc_ext = '0;
        if (acc_open) begin
            acc_ext = {{(EXT_W-ACC_WIDTH){s1_signed & acc[ACC_WIDTH-1]}}, acc};
        end
        sum_ext  = {{(EXT_W-SUM_W){s1_signed & s1_sum[SUM_W-1]}}, s1_sum};
        exact    = acc_ext + sum_ext;
        over_hi  = s1_signed ? ($signed(exact) > $signed(SMAX_EXT)) : (exact > UMAX_EXT);
        over_lo  = s1_signed & ($signed(exact) < $signed(SMIN_EXT));
        acc_next = exact[ACC_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (over_hi) begin
                acc_next = s1_signed ? ACC_SMAX : {ACC_WIDTH{1'b1}};
            end else if (over_lo) begin
                acc_next = ACC_SMIN;
            end
        end
        sticky_next = (acc_open & sticky) | over_hi | over_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_signed <= 1'b0;
            s1_sum    <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum    <= lane_sum;
                s1_last   <= in_last;
                s1_signed <= signed_mode;
            end
        end
    end

    // acc_open=0 means the next beat starts a fresh accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            acc_open  <= 1'b0;
            sticky    <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            s2_valid  <= 1'b0;
            acc_open  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s2_valid & s2_last;
            if (s2_valid && s2_last) begin
                result   <= acc;
                sat_flag <= sticky;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                acc      <= acc_next;
                sticky   <= sticky_next;
                s2_last  <= s1_last;
                acc_open <= !s1_last;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipelined.sv
// Randomized and directed bench for mac_pipelined: three instances (default, wrapping,
// four lanes) share control inputs and are checked against an arithmetic reference model.
module tb_mac_pipelined;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_last, signed_mode, clear;
    logic [7:0]  b1, c1;
    logic [31:0] b4, c4;
    logic        ov0, ov1, ov2, sf0, sf1, sf2;
    logic [15:0] res0, res1, res2;

    int n_chk = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    // Handshake: a beat is accepted on every rising edge where in_valid=1 and clear=0;
    // out_valid is a one-cycle pulse two edges after the last beat, with no backpressure.
    logic [50:0] exp_q[$];
    int          exp_tag[$];
    logic [50:0] last_exp = '0;

    longint m_acc[3];
    bit     m_open[3];
    bit     m_sticky[3];

    mac_pipelined dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .signed_mode(signed_mode), .clear(clear), .B(b1), .C(c1),
        .out_valid(ov0), .result(res0), .sat_flag(sf0)
    );

    mac_pipelined #(.SATURATE(0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .signed_mode(signed_mode), .clear(clear), .B(b1), .C(c1),
        .out_valid(ov1), .result(res1), .sat_flag(sf1)
    );

    mac_pipelined #(.LANES(4)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .signed_mode(signed_mode), .clear(clear), .B(b4), .C(c4),
        .out_valid(ov2), .result(res2), .sat_flag(sf2)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint lv(input logic [7:0] v, input bit sg);
        if (sg) return longint'($signed(v));
        return longint'(v);
    endfunction

    // reference model: exact integer accumulation, then clamp or wrap into 16 bits
    task automatic model_beat(input bit last, input bit sg, input int tag);
        logic [50:0] e;
        longint      dot, ex, hi, lo;
        bit          st, ovf;
        e  = '0;
        hi = sg ? 64'sd32767 : 64'sd65535;
        lo = sg ? -64'sd32768 : 64'sd0;
        for (int i = 0; i < 3; i++) begin
            dot = 0;
            if (i == 2) begin
                for (int k = 0; k < 4; k++) dot += lv(b4[k*8 +: 8], sg) * lv(c4[k*8 +: 8], sg);
            end else begin
                dot = lv(b1, sg) * lv(c1, sg);
            end
            ex  = (m_open[i] ? m_acc[i] : 64'sd0) + dot;
            st  = m_open[i] && m_sticky[i];
            ovf = (ex > hi) || (ex < lo);
            if (ovf) st = 1'b1;
            if (ovf && i != 1) begin
                ex = (ex > hi) ? hi : lo;
            end else if (ovf) begin
                ex = ex & 64'hFFFF;
                if (sg && ex >= 32768) ex -= 65536;
            end
            m_acc[i]    = ex;
            m_sticky[i] = st;
            m_open[i]   = !last;
            e[i*17 +: 17] = {st, ex[15:0]};
        end
        if (last) begin
            exp_q.push_back(e);
            exp_tag.push_back(tag);
        end
    endtask

    // driver tasks: called at posedge+1, return at the next posedge+1
    task automatic drive(input bit v, input bit l, input bit sg, input bit clr,
                         input logic [7:0] b, input logic [7:0] c,
                         input logic [31:0] bb, input logic [31:0] cc);
        in_valid = v; in_last = l; signed_mode = sg; clear = clr;
        b1 = b; c1 = c; b4 = bb; c4 = cc;
        if (clr) begin
            // results of beats accepted in the previous two edges are cancelled
            while (exp_tag.size() > 0 && exp_tag[$] >= edge_cnt - 1) begin
                void'(exp_q.pop_back());
                void'(exp_tag.pop_back());
            end
            for (int i = 0; i < 3; i++) m_open[i] = 1'b0;
        end else if (v) begin
            model_beat(l, sg, edge_cnt + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit l, input bit sg, input logic [7:0] b, input logic [7:0] c);
        drive(1'b1, l, sg, 1'b0, b, c, {24'h0, b}, {24'h0, c});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, signed_mode, 1'b0, 8'h0, 8'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
        #1;
        chk("reset_out_valid", {29'h0, ov2, ov1, ov0}, 32'h0);
        chk("reset_out0", {15'h0, sf0, res0}, 32'h0);
        chk("reset_out1", {15'h0, sf1, res1}, 32'h0);
        chk("reset_out2", {15'h0, sf2, res2}, 32'h0);
        exp_q.delete();
        exp_tag.delete();
        last_exp = '0;
        for (int i = 0; i < 3; i++) begin
            m_open[i] = 1'b0; m_acc[i] = 0; m_sticky[i] = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [7:0] rb();
        case ($urandom_range(0, 5))
            0:       return 8'hFF;
            1:       return 8'h80;
            2:       return 8'h7F;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        bit exp_now;
        if (reset) begin
            if (exp_tag.size() > 0 && exp_tag[0] + 2 < edge_cnt) begin
                n_chk++;
                n_fail++;
                $display("FAIL pulse_missing: tag %0d still pending at edge %0d", exp_tag[0], edge_cnt);
                last_exp = exp_q.pop_front();
                void'(exp_tag.pop_front());
            end
            exp_now = exp_tag.size() > 0 && exp_tag[0] + 2 == edge_cnt;
            chk("out_valid", {29'h0, ov2, ov1, ov0}, {29'h0, {3{exp_now}}});
            if (exp_now) begin
                last_exp = exp_q.pop_front();
                void'(exp_tag.pop_front());
            end
            chk("out0", {15'h0, sf0, res0}, {15'h0, last_exp[16:0]});
            chk("out1", {15'h0, sf1, res1}, {15'h0, last_exp[33:17]});
            chk("out2", {15'h0, sf2, res2}, {15'h0, last_exp[50:34]});
        end
    end

    initial begin
        bit          cur_sg, v, l, clr;
        logic [31:0] bb, cc;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; signed_mode = 1'b0; clear = 1'b0;
        b1 = '0; c1 = '0; b4 = '0; c4 = '0;
        #2;
        do_reset();

        // unsigned three-beat accumulation, exact pulse latency
        beat(1'b0, 1'b0, 8'd5, 8'd3);
        beat(1'b0, 1'b0, 8'd4, 8'd2);
        beat(1'b1, 1'b0, 8'd6, 8'd3);
        idle(2);
        chk("t1_pulse", {31'h0, ov0}, 32'h1);
        chk("t1_result", {16'h0, res0}, 32'd41);
        chk("t1_flag", {31'h0, sf0}, 32'h0);
        idle(1);

        beat(1'b0, 1'b1, 8'hFD, 8'd4);
        beat(1'b1, 1'b1, 8'd2, 8'd5);
        idle(2);
        chk("t2_signed", {15'h0, sf0, res0}, {15'h0, 1'b0, 16'hFFFE});

        beat(1'b0, 1'b1, 8'h80, 8'h80);
        beat(1'b1, 1'b1, 8'h80, 8'h80);
        idle(2);
        chk("t2_signed_sat", {15'h0, sf0, res0}, {15'h0, 1'b1, 16'h7FFF});

        beat(1'b0, 1'b0, 8'hFF, 8'hFF);
        beat(1'b1, 1'b0, 8'hFF, 8'hFF);
        idle(2);
        chk("t3_unsigned_sat", {15'h0, sf0, res0}, {15'h0, 1'b1, 16'hFFFF});
        chk("t3_unsigned_wrap", {15'h0, sf1, res1}, {15'h0, 1'b1, 16'hFC02});

        // back-to-back last beats
        beat(1'b1, 1'b0, 8'd1, 8'd1);
        beat(1'b1, 1'b0, 8'd2, 8'd2);
        idle(1);
        chk("t4_first", {15'h0, ov0, res0}, {15'h0, 1'b1, 16'd1});
        idle(1);
        chk("t4_second", {15'h0, ov0, res0}, {15'h0, 1'b1, 16'd4});
        idle(1);

        // clear right after a last beat drops it and the same-cycle beat
        beat(1'b1, 1'b0, 8'd6, 8'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd9, 8'd9, 32'd9, 32'd9);
        beat(1'b1, 1'b0, 8'd1, 8'd1);
        idle(2);
        chk("t5_after_clear", {15'h0, ov0, res0}, {15'h0, 1'b1, 16'd1});

        bb = {8'd4, 8'd3, 8'd2, 8'd1};
        cc = {8'd8, 8'd7, 8'd6, 8'd5};
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, bb, cc);
        idle(2);
        chk("t6_four_lanes", {16'h0, res2}, 32'd70);
        idle(1);

        // randomized stream with clears and one mid-stream reset
        cur_sg = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) begin
                do_reset();
                cur_sg = 1'($urandom_range(0, 1));
            end
            clr = ($urandom_range(0, 39) == 0);
            v   = ($urandom_range(0, 3) != 0);
            l   = ($urandom_range(0, 3) == 0);
            bb  = {rb(), rb(), rb(), rb()};
            cc  = {rb(), rb(), rb(), rb()};
            drive(v, l, cur_sg, clr, rb(), rb(), bb, cc);
            if (clr || (v && l)) cur_sg = 1'($urandom_range(0, 1));
        end

        idle(6);
        chk("drain_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
